// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control from execute/hazard logic, instruction memory port
// and the registered IF-stage outputs.
interface fetch_unit_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misaligned;
    logic        halted;

    modport slave (
        input  stall, redirect_valid, redirect_target, halt_req, imem_rdata,
        output imem_addr, if_valid, if_pc, if_instr, if_misaligned, halted
    );

    modport master (
        output stall, redirect_valid, redirect_target, halt_req, imem_rdata,
        input  imem_addr, if_valid, if_pc, if_instr, if_misaligned, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing with redirect/halt/stall control and a
// single registered IF output stage fed by a combinational instruction memory.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    fetch_unit_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_if_valid;
    logic        r_misaligned;
    logic        r_halted;
    logic [31:0] w_imem_addr;

    // Memory address depends only on the PC register, never on same-cycle inputs.
    assign w_imem_addr       = {2'b00, r_pc[31:2]};
    assign bus.imem_addr     = w_imem_addr;
    assign bus.if_valid      = r_if_valid;
    assign bus.if_pc         = r_if_pc;
    assign bus.if_instr      = r_if_instr;
    assign bus.if_misaligned = r_misaligned;
    assign bus.halted        = r_halted;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_if_pc      <= RESET_PC;
            r_if_instr   <= NOP;
            r_if_valid   <= 1'b0;
            r_misaligned <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state    <= RUN;
                    r_if_valid <= 1'b0;
                end
                RUN, HALT: begin
                    if (bus.redirect_valid) begin
                        // Squash whatever is in flight; stall does not block a redirect.
                        r_pc         <= {bus.redirect_target[31:2], 2'b00};
                        r_misaligned <= |bus.redirect_target[1:0];
                        r_if_valid   <= 1'b0;
                        r_state      <= RUN;
                        r_halted     <= 1'b0;
                    end else if (r_state == HALT) begin
                        r_if_valid <= 1'b0;
                    end else if (bus.halt_req) begin
                        if (!bus.stall) begin
                            r_if_instr <= bus.imem_rdata;
                            r_if_pc    <= r_pc;
                            r_if_valid <= 1'b1;
                        end else begin
                            r_if_valid <= 1'b0;
                        end
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else if (!bus.stall) begin
                        r_if_instr <= bus.imem_rdata;
                        r_if_pc    <= r_pc;
                        r_if_valid <= 1'b1;
                        r_pc       <= r_pc + 32'd4;
                    end
                end
                default: begin
                    r_state    <= BOOT;
                    r_if_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural model checked every cycle plus directed
// scenarios with hand-computed expectations.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a function of the word address.
    function automatic logic [31:0] memf(input logic [31:0] waddr);
        return {waddr[15:0] ^ 16'h5A5A, waddr[15:0]};
    endfunction

    assign bus.imem_rdata = memf(bus.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Behavioural model: a PC, a boot flag, a halted flag and the IF outputs.
    logic [31:0] m_pc, m_ifpc, m_instr;
    bit          m_valid, m_mis, m_halt, m_boot;

    task automatic model_reset();
        m_pc    = 32'h0;
        m_ifpc  = 32'h0;
        m_instr = 32'h0000_0013;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_halt  = 1'b0;
        m_boot  = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (bus.redirect_valid) begin
            m_pc    = bus.redirect_target & 32'hFFFF_FFFC;
            m_mis   = (bus.redirect_target % 4) != 0;
            m_valid = 1'b0;
            m_halt  = 1'b0;
        end else if (m_halt) begin
            m_valid = 1'b0;
        end else begin
            if (!bus.stall) begin
                m_ifpc  = m_pc;
                m_instr = memf(m_pc / 4);
                m_valid = 1'b1;
                if (!bus.halt_req) m_pc = m_pc + 32'd4;
            end else if (bus.halt_req) begin
                m_valid = 1'b0;
            end
            if (bus.halt_req) m_halt = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_imem_addr", bus.imem_addr, m_pc / 4);
            check("m_if_valid", 32'(bus.if_valid), 32'(m_valid));
            check("m_if_pc", bus.if_pc, m_ifpc);
            check("m_if_instr", bus.if_instr, m_instr);
            check("m_if_misaligned", 32'(bus.if_misaligned), 32'(m_mis));
            check("m_halted", 32'(bus.halted), 32'(m_halt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] t);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = t;
        step();
        bus.redirect_valid  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_imem_addr"}, bus.imem_addr, 32'h0);
        check({tag, "_if_valid"}, 32'(bus.if_valid), 32'h0);
        check({tag, "_if_pc"}, bus.if_pc, 32'h0);
        check({tag, "_if_instr"}, bus.if_instr, 32'h0000_0013);
        check({tag, "_misaligned"}, 32'(bus.if_misaligned), 32'h0);
        check({tag, "_halted"}, 32'(bus.halted), 32'h0);
    endtask

    initial begin
        bus.stall           = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.halt_req        = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_reset_values("rst");
        chk_en = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        // Sequential fetch after reset release.
        for (int k = 1; k <= 10; k++) begin
            step();
            check("seq_imem_addr", bus.imem_addr, (k < 2) ? 32'd0 : 32'(k - 1));
            check("seq_if_valid", 32'(bus.if_valid), (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) check("seq_if_pc", bus.if_pc, 32'(4 * (k - 2)));
        end
        check("seq_if_instr", bus.if_instr, 32'h5A52_0008);

        // Stall held three cycles at pc 0x10.
        redirect(32'h8);
        step();
        step();
        bus.stall = 1'b1;
        check("stall_start_addr", bus.imem_addr, 32'd4);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_imem_addr", bus.imem_addr, 32'd4);
            check("stall_if_pc", bus.if_pc, 32'hC);
            check("stall_if_instr", bus.if_instr, 32'h5A59_0003);
            check("stall_if_valid", 32'(bus.if_valid), 32'd1);
        end
        bus.stall = 1'b0;
        step();
        check("stall_resume_addr", bus.imem_addr, 32'd5);
        check("stall_resume_pc", bus.if_pc, 32'h10);

        // Redirect together with stall.
        bus.stall = 1'b1;
        redirect(32'h88);
        bus.stall = 1'b0;
        check("rdst_imem_addr", bus.imem_addr, 32'd34);
        check("rdst_if_valid", 32'(bus.if_valid), 32'd0);
        step();
        check("rdst_if_pc", bus.if_pc, 32'h88);
        check("rdst_if_valid2", 32'(bus.if_valid), 32'd1);
        check("rdst_imem_addr2", bus.imem_addr, 32'd35);

        // Halt at pc 0x20, then resume via redirect to 0.
        redirect(32'h18);
        step();
        step();
        check("halt_pre_addr", bus.imem_addr, 32'd8);
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        check("halt_halted", 32'(bus.halted), 32'd1);
        check("halt_if_pc", bus.if_pc, 32'h20);
        check("halt_if_instr", bus.if_instr, 32'h5A52_0008);
        for (int k = 0; k < 20; k++) begin
            step();
            check("halt_imem_addr", bus.imem_addr, 32'd8);
            check("halt_if_valid", 32'(bus.if_valid), 32'd0);
            check("halt_hold", 32'(bus.halted), 32'd1);
        end
        redirect(32'h0);
        check("unhalt_halted", 32'(bus.halted), 32'd0);
        check("unhalt_addr", bus.imem_addr, 32'd0);
        check("unhalt_valid", 32'(bus.if_valid), 32'd0);
        step();
        check("unhalt_valid2", 32'(bus.if_valid), 32'd1);
        check("unhalt_if_pc", bus.if_pc, 32'h0);

        // Halt and stall in the same cycle.
        step();
        bus.stall    = 1'b1;
        bus.halt_req = 1'b1;
        step();
        bus.stall    = 1'b0;
        bus.halt_req = 1'b0;
        check("hs_halted", 32'(bus.halted), 32'd1);
        check("hs_if_valid", 32'(bus.if_valid), 32'd0);
        check("hs_if_pc", bus.if_pc, 32'h4);
        check("hs_imem_addr", bus.imem_addr, 32'd2);
        step();
        check("hs_imem_addr2", bus.imem_addr, 32'd2);

        // Misaligned redirect sets the flag, an aligned one clears it.
        redirect(32'h46);
        check("mis_flag", 32'(bus.if_misaligned), 32'd1);
        check("mis_addr", bus.imem_addr, 32'd17);
        check("mis_halted", 32'(bus.halted), 32'd0);
        step();
        step();
        check("mis_flag_hold", 32'(bus.if_misaligned), 32'd1);
        check("mis_if_pc", bus.if_pc, 32'h48);
        redirect(32'h40);
        check("mis_clear", 32'(bus.if_misaligned), 32'd0);
        check("mis_clear_addr", bus.imem_addr, 32'd16);

        // PC wrap at the top of the address space.
        redirect(32'hFFFF_FFFC);
        check("wrap_addr", bus.imem_addr, 32'h3FFF_FFFF);
        step();
        check("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
        check("wrap_addr2", bus.imem_addr, 32'd0);
        step();
        check("wrap_if_pc2", bus.if_pc, 32'h0);

        // Asynchronous reset pulse while running near 0x100.
        redirect(32'h102);
        step();
        step();
        check("pre_rst_if_pc", bus.if_pc, 32'h104);
        check("pre_rst_mis", 32'(bus.if_misaligned), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("rs_addr1", bus.imem_addr, 32'd0);
        check("rs_valid1", 32'(bus.if_valid), 32'd0);
        step();
        check("rs_valid2", 32'(bus.if_valid), 32'd1);
        check("rs_if_pc", bus.if_pc, 32'h0);
        check("rs_if_instr", bus.if_instr, 32'h5A5A_0000);
        check("rs_addr2", bus.imem_addr, 32'd1);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of first instruction fetched after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert handled upstream.
REQ-004 stall  input  1  downstream cannot accept; hold PC and output register.
REQ-005 redirect_valid  input  1  taken branch/jump from execute; overrides sequential PC.
REQ-006 redirect_target  input  32  byte address of redirect destination.
REQ-007 halt_req  input  1  stop fetching (ecall/ebreak/end of test).
REQ-008 imem_addr  output  32  instruction memory word address, = pc[31:2] zero-extended.
REQ-009 imem_rdata  input  32  instruction word, combinational read of imem_addr in same cycle.
REQ-010 if_valid  output  1  if_instr/if_pc hold a valid fetched instruction.
REQ-011 if_pc  output  32  byte address of instruction in if_instr.
REQ-012 if_instr  output  32  registered fetched instruction word.
REQ-013 if_misaligned  output  1  registered flag: redirect_target[1:0] != 0 was accepted.
REQ-014 halted  output  1  high while in HALT state.

Function
REQ-015 State machine: BOOT, RUN, HALT; reset enters BOOT.
REQ-016 BOOT: pc = RESET_PC, if_valid = 0; next cycle unconditionally RUN, no fetch captured.
REQ-017 RUN, per cycle, priority: redirect_valid > halt_req > stall > sequential advance.
REQ-018 Sequential advance: if_instr <= imem_rdata, if_pc <= pc, if_valid <= 1, pc <= pc + 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0 with no flag).
REQ-019 Redirect (RUN or HALT, stall ignored): pc <= {redirect_target[31:2], 2'b00}, if_valid <= 0 for one cycle (squash in-flight fetch), state <= RUN, halted <= 0.
REQ-020 Redirect with redirect_target[1:0] != 0: if_misaligned <= 1 until next accepted redirect with aligned target or reset; fetch proceeds from aligned address.
REQ-021 halt_req without redirect in RUN: current fetch captured as in REQ-018 (if not stalled), then state <= HALT; pc frozen.
REQ-022 HALT: pc, if_pc, if_instr frozen; if_valid <= 0 from first HALT cycle; halted = 1; only redirect or reset leaves HALT.
REQ-023 Stall in RUN without redirect/halt: pc, if_pc, if_instr, if_valid all hold; imem_addr unchanged.
REQ-024 Simultaneous stall and redirect: redirect wins; if_valid <= 0.
REQ-025 Simultaneous halt_req and stall: enter HALT, if_* hold values except if_valid <= 0.
REQ-026 imem_addr is combinational from pc register only; no dependency on inputs in same cycle.
REQ-027 One-cycle fetch latency: instruction at pc appears on if_instr the cycle after pc drives imem_addr.

Reset
REQ-028 rst_n low asynchronously forces: state BOOT, pc = RESET_PC, imem_addr = RESET_PC[31:2], if_valid = 0, if_pc = RESET_PC, if_instr = 32'h0000_0013 (nop), if_misaligned = 0, halted = 0.
REQ-029 Reset mid-operation (any state, any stall/redirect) overrides all, takes effect without a clock edge.
REQ-030 First if_valid = 1 occurs on the second rising edge after rst_n rises (BOOT then first capture).

Verification
REQ-031 Reset release, no stall, 10 cycles -> imem_addr 0,0,1,2,...; if_pc 0,4,8,... one cycle behind; if_valid rises on edge 2.
REQ-032 Redirect_valid=1, target 32'h88, with stall=1 same cycle -> next imem_addr = 34, if_valid = 0 one cycle, then if_pc = 32'h88.
REQ-033 Stall held 3 cycles mid-stream at pc 32'h10 -> imem_addr stays 4, if_instr/if_pc unchanged, resume to imem_addr 5.
REQ-034 halt_req at pc 32'h20 -> instruction at 32'h20 captured, halted = 1, if_valid = 0, imem_addr stays 8 for 20 cycles; redirect to 32'h0 resumes with halted = 0.
REQ-035 Redirect to 32'h46 -> if_misaligned = 1, imem_addr = 17; later redirect to 32'h40 clears flag.
REQ-036 rst_n pulsed low between edges while running at pc 32'h100 -> outputs reach REQ-028 values immediately, restart from RESET_PC.
